// File: rtl/sw_debounce.sv
// Slide-switch conditioner: 2-flop synchroniser, per-channel debounce counter,
// registered level, one-cycle rise/fall pulses and an all-switches-on flag.
module sw_debounce #(
    parameter int CH         = 4,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic [CH-1:0] sw_raw,
    output logic [CH-1:0] sw_level,
    output logic [CH-1:0] sw_rise,
    output logic [CH-1:0] sw_fall,
    output logic          all_on
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CH-1:0] r_s1;
    logic [CH-1:0] r_s2;
    logic [CH-1:0] r_level;
    logic [CH-1:0] r_rise;
    logic [CH-1:0] r_fall;
    logic          r_all_on;
    logic [CW-1:0] r_cnt [CH];

    logic [CH-1:0] w_level_nxt;
    logic [CH-1:0] w_rise_nxt;
    logic [CH-1:0] w_fall_nxt;
    logic [CW-1:0] w_cnt_nxt [CH];

    // A mismatch must persist for DEB_CYCLES consecutive cycles; any agreement clears the count.
    always_comb begin
        w_level_nxt = r_level;
        w_rise_nxt  = '0;
        w_fall_nxt  = '0;
        for (int i = 0; i < CH; i++) begin
            w_cnt_nxt[i] = '0;
        end
        for (int i = 0; i < CH; i++) begin
            if (r_s2[i] != r_level[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_level_nxt[i] = r_s2[i];
                    w_rise_nxt[i]  = r_s2[i];
                    w_fall_nxt[i]  = ~r_s2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_level  <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_all_on <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1     <= sw_raw;
            r_s2     <= r_s1;
            r_level  <= w_level_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            // Built from the next level so the flag moves on the same edge as sw_level.
            r_all_on <= &w_level_nxt;
            for (int i = 0; i < CH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign sw_level = r_level;
    assign sw_rise  = r_rise;
    assign sw_fall  = r_fall;
    assign all_on   = r_all_on;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce (CH=4, DEB_CYCLES=8): directed scenarios plus random
// switch activity, compared against a run-length reference model.
module tb_sw_debounce;

    localparam int CH  = 4;
    localparam int DEB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] raw;
    logic [CH-1:0] sw_level;
    logic [CH-1:0] sw_rise;
    logic [CH-1:0] sw_fall;
    logic          all_on;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the value the design acts on is the raw input sampled two
    // edges earlier; a level is accepted after DEB consecutive disagreeing edges.
    logic [CH-1:0] m_old, m_new;
    logic [CH-1:0] m_level, m_rise, m_fall;
    logic          m_all;
    int            m_run [CH];

    sw_debounce #(.CH(CH), .DEB_CYCLES(DEB)) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .sw_raw   (raw),
        .sw_level (sw_level),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .all_on   (all_on)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic r, input logic [CH-1:0] w);
        m_rise = '0;
        m_fall = '0;
        if (!r) begin
            m_old   = '0;
            m_new   = '0;
            m_level = '0;
            m_all   = 1'b0;
            for (int c = 0; c < CH; c++) m_run[c] = 0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (m_old[c] != m_level[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == DEB) begin
                        m_run[c]   = 0;
                        m_level[c] = m_old[c];
                        if (m_old[c]) m_rise[c] = 1'b1;
                        else          m_fall[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_all = &m_level;
            m_old = m_new;
            m_new = w;
        end
    endtask

    task automatic tick();
        logic          r;
        logic [CH-1:0] w;
        r = rst_n;
        w = raw;
        @(posedge clk);
        model_edge(r, w);
        #1;
    endtask

    task automatic test_reset();
        raw   = 4'hF;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({sw_level, sw_rise, sw_fall, all_on} !== 13'h0) begin
                n_fail++;
                $display("FAIL reset_state edge %0d: got lvl=%h rise=%h fall=%h all=%b, need all zero",
                         k, sw_level, sw_rise, sw_fall, all_on);
            end
        end
    endtask

    task automatic test_clean_press();
        raw   = 4'h1;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++;
            if ({sw_level, sw_rise, sw_fall, all_on} !== {m_level, m_rise, m_fall, m_all}) begin
                n_fail++;
                $display("FAIL clean_model k=%0d: got %h/%h/%h/%b need %h/%h/%h/%b", k,
                         sw_level, sw_rise, sw_fall, all_on, m_level, m_rise, m_fall, m_all);
            end
            n_checks++;
            if ({sw_rise[0], sw_level[0], sw_fall} !== {(k == 10), (k >= 10), 4'h0}) begin
                n_fail++;
                $display("FAIL clean_press k=%0d: rise0=%b lvl0=%b fall=%h, need rise0=%b lvl0=%b fall=0",
                         k, sw_rise[0], sw_level[0], sw_fall, (k == 10), (k >= 10));
            end
        end
    endtask

    task automatic test_bounce();
        int hi [3] = '{3, 5, 7};
        for (int p = 0; p < 3; p++) begin
            for (int h = 0; h < hi[p] + 3; h++) begin
                raw[1] = (h < hi[p]);
                tick();
                n_checks++;
                if ({sw_level[1], sw_rise[1], sw_fall[1]} !== 3'b000 ||
                    {sw_level, sw_rise, sw_fall, all_on} !== {m_level, m_rise, m_fall, m_all}) begin
                    n_fail++;
                    $display("FAIL bounce p=%0d h=%0d: got lvl=%h rise=%h fall=%h need lvl=%h rise=%h fall=%h",
                             p, h, sw_level, sw_rise, sw_fall, m_level, m_rise, m_fall);
                end
            end
        end
        raw[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++;
            if ({sw_rise[1], sw_level[1]} !== {(k == 10), (k >= 10)} ||
                {sw_level, sw_rise, sw_fall, all_on} !== {m_level, m_rise, m_fall, m_all}) begin
                n_fail++;
                $display("FAIL bounce_hold k=%0d: rise1=%b lvl1=%b, need rise1=%b lvl1=%b",
                         k, sw_rise[1], sw_level[1], (k == 10), (k >= 10));
            end
        end
    endtask

    task automatic test_all_on_off();
        raw = 4'h0;
        for (int k = 0; k < 12; k++) tick();
        n_checks++;
        if (sw_level !== 4'h0 || m_level !== 4'h0) begin
            n_fail++;
            $display("FAIL all_clear: got lvl=%h model=%h need 0", sw_level, m_level);
        end
        raw = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if ({sw_rise, sw_level, all_on} !== ((k == 10) ? 9'h1FF : 9'h000)) begin
                n_fail++;
                $display("FAIL all_on k=%0d: rise=%h lvl=%h all=%b", k, sw_rise, sw_level, all_on);
            end
        end
        raw = 4'h7;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if ({sw_fall, sw_level, all_on} !== ((k == 10) ? {4'h8, 4'h7, 1'b0} : {4'h0, 4'hF, 1'b1})) begin
                n_fail++;
                $display("FAIL all_off k=%0d: fall=%h lvl=%h all=%b", k, sw_fall, sw_level, all_on);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        raw   = 4'h0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        raw   = 4'h4;
        for (int k = 0; k < 6; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++;
            if ({sw_rise[2], sw_level[2]} !== {(k == 10), (k >= 10)} ||
                {sw_level, sw_rise, sw_fall, all_on} !== {m_level, m_rise, m_fall, m_all}) begin
                n_fail++;
                $display("FAIL reset_mid k=%0d: rise2=%b lvl2=%b, need rise2=%b lvl2=%b",
                         k, sw_rise[2], sw_level[2], (k == 10), (k >= 10));
            end
        end
    endtask

    task automatic test_independent();
        logic [CH-1:0] exp_rise;
        raw   = 4'h0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        raw   = 4'h1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) raw[3] = 1'b1;
            tick();
            exp_rise = (k == 10) ? 4'h1 : (k == 14) ? 4'h8 : 4'h0;
            n_checks++;
            if (sw_rise !== exp_rise || sw_fall !== 4'h0) begin
                n_fail++;
                $display("FAIL independent k=%0d: rise=%h fall=%h need rise=%h fall=0",
                         k, sw_rise, sw_fall, exp_rise);
            end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] prev_rise = '0;
        logic [CH-1:0] prev_fall = '0;
        for (int k = 0; k < 1500; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 5) == 0) raw[$urandom_range(0, CH-1)] ^= 1'b1;
            tick();
            n_checks++;
            if ({sw_level, sw_rise, sw_fall, all_on} !== {m_level, m_rise, m_fall, m_all}) begin
                n_fail++;
                $display("FAIL random_model k=%0d: got %h/%h/%h/%b need %h/%h/%h/%b", k,
                         sw_level, sw_rise, sw_fall, all_on, m_level, m_rise, m_fall, m_all);
            end
            n_checks++;
            if ((sw_rise & sw_fall) != 0 || (sw_rise & prev_rise) != 0 || (sw_fall & prev_fall) != 0) begin
                n_fail++;
                $display("FAIL random_pulse k=%0d: rise=%h fall=%h prev_rise=%h prev_fall=%h",
                         k, sw_rise, sw_fall, prev_rise, prev_fall);
            end
            prev_rise = sw_rise;
            prev_fall = sw_fall;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        raw   = '0;
        m_old = '0; m_new = '0; m_level = '0; m_rise = '0; m_fall = '0; m_all = 1'b0;
        for (int c = 0; c < CH; c++) m_run[c] = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_all_on_off();
        test_reset_mid_count();
        test_independent();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
